imem_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of the pipelined CPU. It receives a byte stream over a valid/ready handshake, assembles it into 32-bit instruction words, and writes them into the CPU's instruction memory write port. Once the declared number of words is written, it raises `cpu_start` to release the CPU. It replaces bench-side backdoor loading of instruction memory with a synthesizable path.

---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: turns a length-prefixed byte stream into 32-bit instruction memory writes, then releases the CPU.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on any posedge where rx_valid && rx_ready; rx_ready never depends on rx_valid.
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_WORD = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t      state, state_next;
  logic [15:0] len_q;
  logic [23:0] asm_q;
  logic [1:0]  byte_idx;
  logic        accept;
  logic        issue;
  logic        last_word;
  logic [15:0] n_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_ready = (state == S_LEN0) || (state == S_LEN1) || (state == S_WORD) || (state == S_CHK);
`else
  assign rx_ready = (state == S_LEN0) || (state == S_LEN1) || (state == S_WORD);
`endif
  assign busy      = rx_ready;
  assign error     = (state == S_ERR);
  assign accept    = rx_valid && rx_ready;
  assign n_full    = {len_q[15:8], rx_data};
  assign last_word = (int'(words_loaded) + 1) == int'(len_q);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_LEN0: if (accept) state_next = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (n_full == 16'd0)                state_next = S_FINAL;
          else if (int'(n_full) > IMEM_DEPTH) state_next = S_ERR;
          else                                state_next = S_WORD;
        end
      end
      S_WORD: begin
        if (accept && (byte_idx == 2'd3)) begin
          issue = 1'b1;
          if (last_word) state_next = S_FINAL;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_next = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN0;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      asm_q        <= '0;
      byte_idx     <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_start    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we   <= issue;
      // Registered one cycle behind DONE so it never coincides with the final write strobe.
      cpu_start <= (state == S_DONE);
      if (accept) begin
        case (state)
          S_LEN0: len_q[15:8] <= rx_data;
          S_LEN1: len_q[7:0]  <= rx_data;
          S_WORD: begin
            asm_q    <= {asm_q[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ rx_data;
`endif
          end
          default: ;
        endcase
      end
      if (issue) begin
        imem_addr    <= words_loaded[ADDR_W-1:0];
        imem_wdata   <= {asm_q, rx_data};
        words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write scoreboard plus end-of-load status checks.
// Checksum scenarios are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_start;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   words_loaded;
  logic [2:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cyc[$];
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_w;

  imem_loader #(.IMEM_DEPTH(1024), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_start(cpu_start),
    .busy(busy), .error(error), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      we_cyc.push_back(cyc);
      check("we_expected", 64'(exp_q.size() > 0), 64'd1);
      check("start_during_we", 64'(cpu_start), 64'd0);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", 64'({imem_addr, imem_wdata}), 64'(exp_w));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    we_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (g) begin @(posedge clk); #1; end
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], max_gap);
  endtask

  task automatic end_stream(input logic [7:0] csum, input int max_gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum, max_gap);
`else
    if (csum == 8'hff) send_byte(csum, max_gap);
`endif
  endtask

  task automatic expect_start(input string tag, input logic [ADDR_W:0] nwords);
    check({tag, "_start_low_first"}, 64'(cpu_start), 64'd0);
    @(posedge clk); #1;
    check({tag, "_start"}, 64'(cpu_start), 64'd1);
    check({tag, "_words"}, 64'(words_loaded), 64'(nwords));
    check({tag, "_idle"}, 64'({busy, rx_ready, error}), 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    do_reset();
    check("reset_outputs", 64'({rx_ready, imem_we, imem_addr, imem_wdata, cpu_start, busy, error}),
          64'({1'b1, 1'b0, {ADDR_W{1'b0}}, 32'd0, 1'b0, 1'b1, 1'b0}));
    check("reset_words", 64'(words_loaded), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);

    // Two words back to back at one byte per cycle
    exp_q.push_back({10'd0, 32'h20080005});
    exp_q.push_back({10'd1, 32'h8C090000});
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h20080005, 0); send_word(32'h8C090000, 0);
    end_stream(8'hA8, 0);
    expect_start("b2b", 11'd2);
    check("b2b_we_count", 64'(we_cyc.size()), 64'd2);
    if (we_cyc.size() == 2) check("b2b_we_spacing", 64'(we_cyc[1] - we_cyc[0]), 64'd4);

    // Same stream with random idle gaps
    do_reset();
    exp_q.push_back({10'd0, 32'h20080005});
    exp_q.push_back({10'd1, 32'h8C090000});
    send_byte(8'h00, 3); send_byte(8'h02, 3);
    send_word(32'h20080005, 3); send_word(32'h8C090000, 3);
    end_stream(8'hA8, 3);
    expect_start("gaps", 11'd2);
    check("gaps_we_count", 64'(we_cyc.size()), 64'd2);

    // Zero-length image
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    end_stream(8'h00, 0);
    expect_start("zero", 11'd0);
    check("zero_no_we", 64'(we_cyc.size()), 64'd0);

    // Oversized image is rejected and further bytes are ignored
    do_reset();
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    check("over_err", 64'({error, rx_ready, cpu_start, busy}), 64'b1000);
    send_word(32'hDEADBEEF, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("over_sticky", 64'({error, rx_ready, cpu_start}), 64'b100);
    check("over_words", 64'(words_loaded), 64'd0);
    check("over_no_we", 64'(we_cyc.size()), 64'd0);

    // Reset mid-word discards the partial word
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    do_reset();
    check("midrst_state", 64'({busy, rx_ready, imem_we, words_loaded}), 64'({1'b1, 1'b1, 1'b0, 11'd0}));
    exp_q.push_back({10'd0, 32'h11223344});
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h11223344, 0);
    end_stream(8'h44, 0);
    expect_start("midrst", 11'd1);

    // Reset on the same edge as the 4th byte suppresses the write
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
    rx_data = 8'h88; rx_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rst = 1'b0;
    check("rst4_no_we", 64'({imem_we, words_loaded}), 64'd0);
    @(posedge clk); #1;
    check("rst4_no_we_later", 64'(imem_we), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good and bad checksum
    do_reset();
    exp_q.push_back({10'd0, 32'h01020304});
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h01020304, 0);
    send_byte(8'h04, 0);
    expect_start("csum_ok", 11'd1);

    do_reset();
    exp_q.push_back({10'd0, 32'h01020304});
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h01020304, 0);
    send_byte(8'h05, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("csum_bad", 64'({error, cpu_start, rx_ready}), 64'b100);
    check("csum_bad_queue", 64'(exp_q.size()), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
